// File: rtl/core_pkg.sv
// core_pkg: shared types for the regfile/ALU/flag execute core.
//  alu_op_t : 3-bit ALU opcode
//  cc_t     : 3-bit condition code
//  state_t  : execute FSM state
//  FLAG_*   : bit positions inside the {N,Z,C,V} flag vector
//  cc_eval  : evaluates a condition code against a flag vector
package core_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_SLL   = 3'b101,
    OP_SRL   = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_t;

  typedef enum logic [2:0] {
    CC_EQ = 3'b000,
    CC_NE = 3'b001,
    CC_LT = 3'b010,
    CC_GE = 3'b011,
    CC_CS = 3'b100,
    CC_CC = 3'b101,
    CC_NV = 3'b110,
    CC_AL = 3'b111
  } cc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cc_eval(input cc_t cc, input logic [3:0] f);
    logic r;
    case (cc)
      CC_EQ:   r = f[FLAG_Z];
      CC_NE:   r = !f[FLAG_Z];
      CC_LT:   r = f[FLAG_N] ^ f[FLAG_V];
      CC_GE:   r = !(f[FLAG_N] ^ f[FLAG_V]);
      CC_CS:   r = f[FLAG_C];
      CC_CC:   r = !f[FLAG_C];
      CC_NV:   r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core_alu.sv
// core_alu: combinational ALU with next-flag generation.
//  i_a, i_b  : operands (WIDTH)
//  i_op      : alu_op_t
//  o_result  : result truncated to WIDTH
//  o_flags   : next {N,Z,C,V}; C/V meaningful only for ADD/SUB, else 0
module core_alu
  import core_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_t          i_op,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SH_W-1:0]  w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the widened difference is the borrow; carry is its inverse (A >= B).
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_sh   = i_b[SH_W-1:0];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = !w_diff[WIDTH];
        w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_SLL:  w_res = i_a << w_sh;
      OP_SRL:  w_res = i_a >> w_sh;
      default: w_res = i_b;
    endcase
  end

  assign o_result        = w_res;
  assign o_flags[FLAG_N] = w_res[WIDTH-1];
  assign o_flags[FLAG_Z] = (w_res == '0);
  assign o_flags[FLAG_C] = w_c;
  assign o_flags[FLAG_V] = w_v;

endmodule

// File: rtl/regfile_alu_flag_core.sv
// regfile_alu_flag_core: execute core (register file + ALU + flags) behind a
// request/response handshake. FSM IDLE->READ->EXEC->RESP; flags, predicated
// writeback and the response latch all commit on the EXEC->RESP edge.
//  CLK, RESET         : clock, async active-low reset
//  req_*              : request handshake and fields (op, rs1, rs2, rd, srcb, imm, fu, cc, we)
//  resp_*             : response handshake, result, condition outcome
//  flags              : architectural {N,Z,C,V}
//  dbg_we/addr/wdata  : debug register write, honoured only in IDLE, beats requests
//  trap               : sticky overflow trap
// Optional feature macro: CORE_OVF_TRAP_EN (overflow with flag update sets
// trap and suppresses writeback). Undefined: trap is tied 0.
module regfile_alu_flag_core
  import core_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  alu_op_t           req_op,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_srcb,
  input  logic [WIDTH-1:0]  req_imm,
  input  logic              req_fu,
  input  cc_t               req_cc,
  input  logic              req_we,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_result,
  output logic              resp_perform,
  output logic [3:0]        flags,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [WIDTH-1:0]  dbg_wdata,
  output logic              trap
);

  localparam int NREG = 2 ** ADDR_W;

  state_t            r_state;
  logic [WIDTH-1:0]  r_regs [NREG];
  alu_op_t           r_op;
  logic [ADDR_W-1:0] r_rs1, r_rs2, r_rd;
  logic              r_srcb, r_fu, r_we;
  logic [WIDTH-1:0]  r_imm;
  cc_t               r_cc;
  logic [WIDTH-1:0]  r_a, r_b;
  logic [WIDTH-1:0]  r_result;
  logic              r_perform;
  logic [3:0]        r_flags;

  logic [WIDTH-1:0]  w_alu_res;
  logic [3:0]        w_alu_flags;
  logic [3:0]        w_flags_commit;
  logic              w_perform;
  logic              w_trap_hit;
  logic              w_wb;
  logic              w_accept;
  logic              w_dbg_wr;

  assign req_ready    = (r_state == ST_IDLE) && !dbg_we;
  assign w_accept     = req_valid && req_ready;
  assign w_dbg_wr     = dbg_we && (r_state == ST_IDLE);
  assign resp_valid   = (r_state == ST_RESP);
  assign resp_result  = r_result;
  assign resp_perform = r_perform;
  assign flags        = r_flags;

  core_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_res),
    .o_flags  (w_alu_flags)
  );

  // Condition is evaluated against the flags as they will be after this op commits.
  assign w_flags_commit = r_fu ? w_alu_flags : r_flags;
  assign w_perform      = cc_eval(r_cc, w_flags_commit);
  assign w_wb           = r_we && w_perform && !w_trap_hit;

`ifdef CORE_OVF_TRAP_EN
  logic r_trap;
  assign w_trap_hit = r_fu && w_alu_flags[FLAG_V];
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                              r_trap <= 1'b0;
    else if (r_state == ST_EXEC && w_trap_hit) r_trap <= 1'b1;
  end
  assign trap = r_trap;
`else
  assign w_trap_hit = 1'b0;
  assign trap       = 1'b0;
`endif

  // FSM, request latch, operand latch, response and flag registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_ADD;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_srcb    <= 1'b0;
      r_imm     <= '0;
      r_fu      <= 1'b0;
      r_cc      <= CC_EQ;
      r_we      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_perform <= 1'b0;
      r_flags   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op    <= req_op;
          r_rs1   <= req_rs1;
          r_rs2   <= req_rs2;
          r_rd    <= req_rd;
          r_srcb  <= req_srcb;
          r_imm   <= req_imm;
          r_fu    <= req_fu;
          r_cc    <= req_cc;
          r_we    <= req_we;
          r_state <= ST_READ;
        end
        ST_READ: begin
          r_a     <= r_regs[r_rs1];
          r_b     <= r_srcb ? r_imm : r_regs[r_rs2];
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_result  <= w_alu_res;
          r_perform <= w_perform;
          r_flags   <= w_flags_commit;
          r_state   <= ST_RESP;
        end
        ST_RESP: if (resp_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Register file: debug writes only in IDLE, predicated writeback on EXEC->RESP.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_dbg_wr) begin
      r_regs[dbg_addr] <= dbg_wdata;
    end else if (r_state == ST_EXEC && w_wb) begin
      r_regs[r_rd] <= w_alu_res;
    end
  end

endmodule

// File: tb/tb_regfile_alu_flag_core.sv
module tb_regfile_alu_flag_core;
  import core_pkg::*;

`ifdef CORE_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid, req_ready, req_srcb, req_fu, req_we;
  alu_op_t     req_op;
  logic [3:0]  req_rs1, req_rs2, req_rd;
  logic [15:0] req_imm;
  cc_t         req_cc;
  logic        resp_valid, resp_ready, resp_perform;
  logic [15:0] resp_result;
  logic [3:0]  flags;
  logic        dbg_we;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        trap;

  int errs = 0;
  int checks = 0;
  logic [15:0] g_res;
  logic        g_perf;
  logic [3:0]  g_flags;

  always #5 CLK = ~CLK;

  regfile_alu_flag_core #(.WIDTH(16), .ADDR_W(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_srcb(req_srcb), .req_imm(req_imm), .req_fu(req_fu),
    .req_cc(req_cc), .req_we(req_we),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_perform(resp_perform), .flags(flags),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .trap(trap)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic dbg_wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge CLK);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(negedge CLK);
    dbg_we = 1'b0;
  endtask

  task automatic drive(input alu_op_t op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic srcb, input logic [15:0] imm,
                       input logic fu, input cc_t cc, input logic we);
    req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_srcb = srcb;
    req_imm = imm; req_fu = fu; req_cc = cc; req_we = we;
  endtask

  // One full transaction; checks the 3-cycle latency and captures the response.
  task automatic run_op(input alu_op_t op, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [3:0] rd, input logic srcb, input logic [15:0] imm,
                        input logic fu, input cc_t cc, input logic we);
    int n;
    @(negedge CLK);
    drive(op, rs1, rs2, rd, srcb, imm, fu, cc, we);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge CLK); n++; end
    chk("accept_timeout", 32'(n < 20), 1);
    @(negedge CLK); req_valid = 1'b0;
    chk("lat_t1", resp_valid, 0);
    @(negedge CLK);
    chk("lat_t2", resp_valid, 0);
    @(negedge CLK);
    chk("lat_t3", resp_valid, 1);
    g_res = resp_result; g_perf = resp_perform; g_flags = flags;
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a);
    run_op(OP_PASSB, 4'd0, a, 4'd0, 1'b0, 16'h0, 1'b0, CC_AL, 1'b0);
  endtask

  typedef struct {
    alu_op_t op; logic [3:0] rs1; logic [3:0] rs2; logic srcb; logic [15:0] imm;
    cc_t cc; logic [15:0] res; logic [3:0] fl; logic perf;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // R1=0x000F, R0=0x0001, R5=0x7FFF at table time; fu=1, we=0 throughout
    tbl[0] = '{OP_AND, 4'd1, 4'd0, 1'b1, 16'h000C, CC_GE, 16'h000C, 4'b0000, 1'b1};
    tbl[1] = '{OP_OR,  4'd1, 4'd0, 1'b1, 16'h0030, CC_NV, 16'h003F, 4'b0000, 1'b0};
    tbl[2] = '{OP_XOR, 4'd1, 4'd0, 1'b1, 16'h000F, CC_EQ, 16'h0000, 4'b0100, 1'b1};
    tbl[3] = '{OP_SLL, 4'd1, 4'd0, 1'b1, 16'h0013, CC_CC, 16'h0078, 4'b0000, 1'b1};
    tbl[4] = '{OP_SRL, 4'd5, 4'd0, 1'b1, 16'h0003, CC_NE, 16'h0FFF, 4'b0000, 1'b1};
    tbl[5] = '{OP_SUB, 4'd0, 4'd1, 1'b0, 16'h0000, CC_LT, 16'hFFF2, 4'b1000, 1'b1};
    tbl[6] = '{OP_ADD, 4'd5, 4'd0, 1'b1, 16'h8001, CC_CS, 16'h0000, 4'b0110, 1'b1};
    tbl[7] = '{OP_SUB, 4'd5, 4'd0, 1'b1, 16'hFFFF, CC_GE, 16'h8000, 4'b1001, 1'b1};

    RESET = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; dbg_we = 1'b0;
    dbg_addr = '0; dbg_wdata = '0;
    drive(OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 1'b0, CC_EQ, 1'b0);
    repeat (3) @(negedge CLK);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_flags", flags, 0);
    chk("rst_trap", trap, 0);
    chk("rst_result", resp_result, 0);
    chk("rst_perform", resp_perform, 0);
    RESET = 1'b1;

    dbg_wr(4'd0, 16'h0001);
    dbg_wr(4'd1, 16'h000F);
    dbg_wr(4'd3, 16'h00AA);

    run_op(OP_ADD, 4'd0, 4'd1, 4'd2, 1'b0, 16'h0, 1'b1, CC_AL, 1'b1);
    chk("add_res", g_res, 16'h0010); chk("add_perf", g_perf, 1); chk("add_flags", g_flags, 4'b0000);
    rd_reg(4'd2); chk("add_R2", g_res, 16'h0010);

    run_op(OP_SUB, 4'd0, 4'd0, 4'd3, 1'b0, 16'h0, 1'b1, CC_NE, 1'b1);
    chk("sub_res", g_res, 16'h0000); chk("sub_perf", g_perf, 0); chk("sub_flags", g_flags, 4'b0110);
    rd_reg(4'd3); chk("sub_R3_kept", g_res, 16'h00AA);

    run_op(OP_PASSB, 4'd0, 4'd0, 4'd4, 1'b1, 16'h0004, 1'b0, CC_AL, 1'b1);
    chk("passb_res", g_res, 16'h0004); chk("passb_perf", g_perf, 1);
    chk("passb_flags_kept", g_flags, 4'b0110);
    rd_reg(4'd4); chk("passb_R4", g_res, 16'h0004);

    dbg_wr(4'd5, 16'h7FFF);
    dbg_wr(4'd7, 16'h0033);
    run_op(OP_ADD, 4'd5, 4'd0, 4'd6, 1'b1, 16'h0001, 1'b1, CC_LT, 1'b1);
    chk("ovf_res", g_res, 16'h8000); chk("ovf_perf", g_perf, 0); chk("ovf_flags", g_flags, 4'b1001);
    chk("ovf_trap", trap, TRAP);
    rd_reg(4'd6); chk("ovf_R6_kept", g_res, 16'h0000);
    run_op(OP_ADD, 4'd5, 4'd0, 4'd7, 1'b1, 16'h0001, 1'b1, CC_AL, 1'b1);
    chk("ovf_al_perf", g_perf, 1);
    rd_reg(4'd7); chk("ovf_al_R7", g_res, TRAP ? 16'h0033 : 16'h8000);

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].op, tbl[i].rs1, tbl[i].rs2, 4'd0, tbl[i].srcb, tbl[i].imm, 1'b1, tbl[i].cc, 1'b0);
      chk($sformatf("tbl%0d_res", i), g_res, tbl[i].res);
      chk($sformatf("tbl%0d_flags", i), g_flags, tbl[i].fl);
      chk($sformatf("tbl%0d_perf", i), g_perf, tbl[i].perf);
    end

    // Backpressure: response held 5 cycles with a new request waiting
    @(negedge CLK);
    drive(OP_ADD, 4'd0, 4'd1, 4'd0, 1'b0, 16'h0, 1'b1, CC_AL, 1'b0);
    req_valid = 1'b1;
    repeat (3) @(negedge CLK);
    drive(OP_XOR, 4'd1, 4'd1, 4'd2, 1'b0, 16'h0, 1'b1, CC_EQ, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", resp_valid, 1);
      chk("bp_result", resp_result, 16'h0010);
      chk("bp_flags", flags, 4'b0000);
      chk("bp_req_ready", req_ready, 0);
      @(negedge CLK);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
    chk("bp_released", resp_valid, 0);
    rd_reg(4'd2); chk("bp_R2_kept", g_res, 16'h0010);

    // Debug write collides with a request in IDLE
    @(negedge CLK);
    dbg_we = 1'b1; dbg_addr = 4'd9; dbg_wdata = 16'h1234;
    drive(OP_ADD, 4'd0, 4'd1, 4'd9, 1'b0, 16'h0, 1'b1, CC_AL, 1'b1);
    req_valid = 1'b1;
    #1 chk("dbg_req_ready", req_ready, 0);
    @(negedge CLK);
    dbg_we = 1'b0; req_valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk("dbg_no_accept", resp_valid, 0);
    rd_reg(4'd9); chk("dbg_R9", g_res, 16'h1234);

    // Reset asserted while an op is in EXEC
    run_op(OP_SUB, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 1'b1, CC_AL, 1'b0);
    chk("pre_rst_flags", g_flags, 4'b0110);
    @(negedge CLK);
    drive(OP_ADD, 4'd0, 4'd1, 4'd8, 1'b0, 16'h0, 1'b1, CC_AL, 1'b1);
    req_valid = 1'b1;
    @(negedge CLK); req_valid = 1'b0;
    @(negedge CLK);
    chk("exec_req_ready", req_ready, 0);
    RESET = 1'b0;
    #1;
    chk("mrst_resp_valid", resp_valid, 0);
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_flags", flags, 0);
    chk("mrst_trap", trap, 0);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (4) @(negedge CLK);
    chk("mrst_idle", resp_valid, 0);
    rd_reg(4'd8); chk("mrst_R8", g_res, 16'h0000);
    rd_reg(4'd1); chk("mrst_R1", g_res, 16'h0000);
    dbg_wr(4'd1, 16'h0003);
    run_op(OP_ADD, 4'd1, 4'd0, 4'd10, 1'b1, 16'h0002, 1'b1, CC_AL, 1'b1);
    chk("post_res", g_res, 16'h0005); chk("post_perf", g_perf, 1); chk("post_flags", g_flags, 4'b0000);
    rd_reg(4'd10); chk("post_R10", g_res, 16'h0005);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
